mem_port_arbiter: RTL and testbench

//  - Arbitrates NUM_PORTS master request channels (imem, dmem, later L1 refill/DMA) onto one downstream memory port.
//  - Generalises the fixed two-bus imem/dmem split into an N-channel, round-robin, variable-latency req/ack fabric.
//  - Sits between Core (and future caches) and the single-ported backing memory inside the top-level SoC.

---
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter folding NUM_PORTS req/ack master channels onto one downstream memory port.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that ends stalled accesses with an m_err pulse.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              m_req,
  input  logic [NUM_PORTS-1:0]              m_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   m_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   m_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] m_wmask,
  output logic [NUM_PORTS-1:0]              m_ack,
  output logic [NUM_PORTS-1:0]              m_err,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              s_req,
  output logic                              s_we,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [DATA_WIDTH/8-1:0]           s_wmask,
  input  logic                              s_ack,
  input  logic [DATA_WIDTH-1:0]             s_rdata
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned MW = DATA_WIDTH / 8;

  if (NUM_PORTS < 1 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1 || (DATA_WIDTH % 8) != 0)
  begin : gen_bad_cfg
    $error("mem_port_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MW-1:0]         wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  pick_valid;
  logic [PW-1:0]         pick_idx;
  logic [PW-1:0]         cand;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
  logic [MW-1:0]         wmask_arr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_unpack
    assign addr_arr[g]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign wmask_arr[g] = m_wmask[g*MW +: MW];
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // First requester after the last winner, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 1; i <= int'(NUM_PORTS); i++) begin
      cand = PW'((int'(rr_ptr_q) + i) % int'(NUM_PORTS));
      if (!pick_valid && m_req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rdata_d  = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d  = StIssue;
          grant_d  = pick_idx;
          rr_ptr_d = pick_idx;
          we_d     = m_we[pick_idx];
          addr_d   = addr_arr[pick_idx];
          wdata_d  = wdata_arr[pick_idx];
          wmask_d  = wmask_arr[pick_idx];
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d    = '0;
          err_d    = 1'b0;
`endif
        end
      end
      StIssue: begin
        if (s_ack) begin
          rdata_d = s_rdata;
          state_d = StResp;
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= PW'(NUM_PORTS - 1);
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    m_ack = '0;
    m_err = '0;
    if (state_q == StResp) begin
      m_ack[grant_q] = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
      m_err[grant_q] = err_q;
`endif
    end
  end

  assign s_req   = (state_q == StIssue);
  assign s_we    = we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_wmask = wmask_q;
  assign m_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level round-robin model.
module tb_mem_port_arbiter;

  localparam int NP = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = DW / 8;

  logic             clk, rst;
  logic [NP-1:0]    m_req, m_we, m_ack, m_err;
  logic [NP*AW-1:0] m_addr;
  logic [NP*DW-1:0] m_wdata;
  logic [NP*MW-1:0] m_wmask;
  logic [DW-1:0]    m_rdata;
  logic             s_req, s_we, s_ack;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata, s_rdata;
  logic [MW-1:0]    s_wmask;

  logic             we_drv    [NP];
  logic [AW-1:0]    addr_drv  [NP];
  logic [DW-1:0]    wdata_drv [NP];
  logic [MW-1:0]    wmask_drv [NP];

  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < NP; g++) begin : gen_pack
    assign m_we[g]             = we_drv[g];
    assign m_addr[g*AW +: AW]  = addr_drv[g];
    assign m_wdata[g*DW +: DW] = wdata_drv[g];
    assign m_wmask[g*MW +: MW] = wmask_drv[g];
  end

  mem_port_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .NUM_PORTS     (NP),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_we   (m_we),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_wmask(m_wmask),
    .m_ack  (m_ack),
    .m_err  (m_err),
    .m_rdata(m_rdata),
    .s_req  (s_req),
    .s_we   (s_we),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_wmask(s_wmask),
    .s_ack  (s_ack),
    .s_rdata(s_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    m_req   = '0;
    s_ack   = 1'b0;
    s_rdata = '0;
    for (int p = 0; p < NP; p++) begin
      we_drv[p]    = 1'b0;
      addr_drv[p]  = '0;
      wdata_drv[p] = '0;
      wmask_drv[p] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic new_payload(input int p);
    we_drv[p]    = 1'($urandom_range(0, 1));
    addr_drv[p]  = $urandom;
    wdata_drv[p] = $urandom;
    wmask_drv[p] = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_req, s_we, s_addr, s_wdata, s_wmask} !== '0)
      $display("FAIL reset_s_port: got %b/%b/%h/%h/%b want all zero", s_req, s_we, s_addr,
               s_wdata, s_wmask);
    else n_pass++;
    n_checks++;
    if ({m_ack, m_err, m_rdata} !== '0)
      $display("FAIL reset_m_port: got ack %b err %b rdata %h want zero", m_ack, m_err, m_rdata);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    m_req       = 3'b001;
    addr_drv[0] = 32'h10;
    @(negedge clk);
    n_checks++;
    if ({s_req, s_we, s_addr} !== {1'b1, 1'b0, 32'h10})
      $display("FAIL read_issue: got req %b we %b addr %h want 1 0 00000010", s_req, s_we, s_addr);
    else n_pass++;
    s_ack   = 1'b1;
    s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if ({s_req, m_ack, m_rdata} !== {1'b0, 3'b001, 32'hDEADBEEF})
      $display("FAIL read_resp: got s_req %b ack %b rdata %h want 0 001 deadbeef", s_req, m_ack,
               m_rdata);
    else n_pass++;
    m_req   = '0;
    s_ack   = 1'b0;
    s_rdata = '0;
    @(negedge clk);
    n_checks++;
    if ({m_ack, m_rdata} !== {3'b000, 32'hDEADBEEF})
      $display("FAIL read_hold: got ack %b rdata %h want 000 deadbeef", m_ack, m_rdata);
    else n_pass++;
  endtask

  task automatic test_alternate();
    int acks = 0;
    bit multi = 1'b0;
    do_reset();
    addr_drv[0] = 32'h100;
    addr_drv[1] = 32'h104;
    m_req       = 3'b011;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      @(negedge clk);
      if ($countones(m_ack) > 1) multi = 1'b1;
      if (m_ack !== 3'b000) begin
        n_checks++;
        if (m_ack !== (3'b001 << (acks % 2)))
          $display("FAIL alt_order #%0d: got %b want %b", acks, m_ack, 3'b001 << (acks % 2));
        else n_pass++;
        acks++;
      end
      s_ack = s_req;
    end
    m_req = '0;
    s_ack = 1'b0;
    n_checks++;
    if (acks != 4) $display("FAIL alt_count: got %0d acks want 4", acks);
    else n_pass++;
    n_checks++;
    if (multi) $display("FAIL alt_onehot: got multiple acks in a cycle want at most one");
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_write_delayed();
    do_reset();
    m_req        = 3'b010;
    we_drv[1]    = 1'b1;
    addr_drv[1]  = 32'h20;
    wdata_drv[1] = 32'h12345678;
    wmask_drv[1] = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({s_req, s_we, s_addr, s_wdata, s_wmask} !== {1'b1, 1'b1, 32'h20, 32'h12345678, 4'b0011})
        $display("FAIL wr_payload cyc %0d: got %b %b %h %h %b want 1 1 00000020 12345678 0011",
                 i, s_req, s_we, s_addr, s_wdata, s_wmask);
      else n_pass++;
      n_checks++;
      if (m_ack !== 3'b000) $display("FAIL wr_early_ack cyc %0d: got %b want 000", i, m_ack);
      else n_pass++;
      s_ack = (i == 4);
    end
    @(negedge clk);
    n_checks++;
    if (m_ack !== 3'b010) $display("FAIL wr_ack: got %b want 010", m_ack);
    else n_pass++;
    s_ack = 1'b0;
    m_req = '0;
    @(negedge clk);
    n_checks++;
    if (m_ack !== 3'b000) $display("FAIL wr_single: got %b want 000", m_ack);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_req       = 3'b010;
    addr_drv[1] = 32'h30;
    @(negedge clk);
    n_checks++;
    if (s_req !== 1'b1) $display("FAIL rstmid_issue: got %b want 1", s_req);
    else n_pass++;
    rst         = 1'b1;
    m_req       = 3'b111;
    addr_drv[0] = 32'h50;
    addr_drv[2] = 32'h70;
    @(negedge clk);
    n_checks++;
    if ({s_req, m_ack} !== 4'b0000) $display("FAIL rstmid_abort: got req %b ack %b want 0 000",
                                             s_req, m_ack);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_ack, s_req, s_addr} !== {3'b000, 1'b1, 32'h50})
      $display("FAIL rstmid_regrant: got ack %b req %b addr %h want 000 1 00000050", m_ack, s_req,
               s_addr);
    else n_pass++;
    s_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_ack !== 3'b001) $display("FAIL rstmid_ack: got %b want 001", m_ack);
    else n_pass++;
    m_req = '0;
    s_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latch_addr();
    do_reset();
    m_req       = 3'b001;
    addr_drv[0] = 32'h40;
    @(negedge clk);
    addr_drv[0] = 32'h80;
    @(negedge clk);
    n_checks++;
    if ({s_req, s_addr} !== {1'b1, 32'h40})
      $display("FAIL latch_addr: got req %b addr %h want 1 00000040", s_req, s_addr);
    else n_pass++;
    s_ack = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_ack !== 3'b001) $display("FAIL latch_ack: got %b want 001", m_ack);
    else n_pass++;
    s_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({s_req, m_ack} !== 4'b0000) $display("FAIL lone_gap: got req %b ack %b want 0 000",
                                             s_req, m_ack);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({s_req, s_addr} !== {1'b1, 32'h80})
      $display("FAIL lone_regrant: got req %b addr %h want 1 00000080", s_req, s_addr);
    else n_pass++;
    s_ack = 1'b1;
    @(negedge clk);
    m_req = '0;
    s_ack = 1'b0;
    @(negedge clk);
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k = -1;
    do_reset();
    m_req       = 3'b001;
    addr_drv[0] = 32'h44;
    @(negedge clk);
    s_ack   = 1'b1;
    s_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    n_checks++;
    if ({m_ack, m_err} !== {3'b001, 3'b000})
      $display("FAIL to_normal: got ack %b err %b want 001 000", m_ack, m_err);
    else n_pass++;
    s_ack = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (k >= 0) k++;
      else if (s_req) k = 0;
      if (m_ack !== 3'b000) break;
    end
    n_checks++;
    if (k != 8) $display("FAIL to_latency: got %0d cycles want 8", k);
    else n_pass++;
    n_checks++;
    if ({m_ack, m_err, m_rdata, s_req} !== {3'b001, 3'b001, 32'h0, 1'b0})
      $display("FAIL to_resp: got ack %b err %b rdata %h req %b want 001 001 0 0", m_ack, m_err,
               m_rdata, s_req);
    else n_pass++;
    m_req = '0;
    @(negedge clk);
    n_checks++;
    if ({m_ack, m_err} !== 6'b0) $display("FAIL to_single: got ack %b err %b want 0", m_ack, m_err);
    else n_pass++;
  endtask
`endif

  // Model: one transaction at a time; winner = first requester after the previous winner.
  task automatic test_random();
    int last, cur, wait_cyc, txns, p;
    bit free, pend_free, exp_grant, in_issue, exp_ack;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata, exp_rdata;
    logic [MW-1:0] lat_wmask;
    logic [NP-1:0] exp_ack_v;
    do_reset();
    last = NP - 1; cur = 0; wait_cyc = 0; txns = 0;
    free = 1'b1; pend_free = 1'b0; exp_grant = 1'b0; in_issue = 1'b0; exp_ack = 1'b0;
    lat_we = 1'b0; lat_addr = '0; lat_wdata = '0; lat_wmask = '0; exp_rdata = '0;
    for (int c = 0; c < 4000 && txns < 200; c++) begin
      @(negedge clk);
      n_checks++;
      if (s_req !== (exp_grant || in_issue))
        $display("FAIL rnd_s_req cyc %0d: got %b want %b", c, s_req, exp_grant || in_issue);
      else n_pass++;
      if (exp_grant || in_issue) begin
        n_checks++;
        if ({s_we, s_addr, s_wdata, s_wmask} !== {lat_we, lat_addr, lat_wdata, lat_wmask})
          $display("FAIL rnd_payload cyc %0d: got %b %h %h %b want %b %h %h %b", c, s_we, s_addr,
                   s_wdata, s_wmask, lat_we, lat_addr, lat_wdata, lat_wmask);
        else n_pass++;
      end
      exp_ack_v = exp_ack ? (3'b001 << cur) : 3'b000;
      n_checks++;
      if (m_ack !== exp_ack_v) $display("FAIL rnd_ack cyc %0d: got %b want %b", c, m_ack, exp_ack_v);
      else n_pass++;
      n_checks++;
      if (m_rdata !== exp_rdata)
        $display("FAIL rnd_rdata cyc %0d: got %h want %h", c, m_rdata, exp_rdata);
      else n_pass++;
      n_checks++;
      if (m_err !== 3'b000) $display("FAIL rnd_err cyc %0d: got %b want 000", c, m_err);
      else n_pass++;

      if (pend_free) begin free = 1'b1; pend_free = 1'b0; end
      if (exp_grant) begin exp_grant = 1'b0; in_issue = 1'b1; wait_cyc = 0; end
      if (exp_ack) begin
        exp_ack = 1'b0;
        pend_free = 1'b1;
        txns++;
        if ($urandom_range(0, 1) == 0) m_req[cur] = 1'b0;
        else new_payload(cur);
      end
      if (in_issue) begin
        addr_drv[cur]  = $urandom;
        wdata_drv[cur] = $urandom;
        if (wait_cyc >= 4 || $urandom_range(0, 2) == 0) begin
          s_ack     = 1'b1;
          s_rdata   = $urandom;
          exp_rdata = s_rdata;
          in_issue  = 1'b0;
          exp_ack   = 1'b1;
        end else begin
          s_ack = 1'b0;
          wait_cyc++;
        end
      end else begin
        s_ack   = ($urandom_range(0, 3) == 0);
        s_rdata = $urandom;
      end
      for (int q = 0; q < NP; q++) begin
        if (!m_req[q] && $urandom_range(0, 3) == 0) begin
          new_payload(q);
          m_req[q] = 1'b1;
        end
      end
      if (free && m_req != '0) begin
        cur = -1;
        for (int i = 1; i <= NP; i++) begin
          p = (last + i) % NP;
          if (cur < 0 && m_req[p]) cur = p;
        end
        last      = cur;
        lat_we    = we_drv[cur];
        lat_addr  = addr_drv[cur];
        lat_wdata = wdata_drv[cur];
        lat_wmask = wmask_drv[cur];
        exp_grant = 1'b1;
        free      = 1'b0;
      end
    end
    n_checks++;
    if (txns < 200) $display("FAIL rnd_progress: got %0d transactions want 200", txns);
    else n_pass++;
    m_req = '0;
    s_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_alternate();
    test_write_delayed();
    test_reset_mid();
    test_latch_addr();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
